// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - show-ahead FIFO pop handshake between a FIFO and its consumer
//
// Signals:
//   fifo_val   FIFO non-empty; fifo_data is valid whenever it is high
//   fifo_data  FIFO head word (DATA_W bits)
//   fifo_read  one-cycle pop strobe driven by the consumer
// Modports:
//   master  FIFO side (drives val/data, receives read)
//   slave   consumer side (receives val/data, drives read)
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              fifo_val;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read;

    modport master (
        output fifo_val,
        output fifo_data,
        input  fifo_read
    );

    modport slave (
        input  fifo_val,
        input  fifo_data,
        output fifo_read
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that drains a show-ahead FIFO one word per frame
//
// Pops a word from the FIFO and sends it as start bit, DATA_W data bits
// (LSB first) and STOP_BITS stop bits, each bit lasting CLK_DIV clocks.
// Frames run back to back while the FIFO stays non-empty.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   fifo  FIFO handshake (slave side): fifo_val/fifo_data in, fifo_read out
//   tx    registered serial line, idles high
//   busy  high while a frame is in progress
module fifo_uart_tx #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  fifo,
    output logic           tx,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;

    logic bit_end;
    logic last_stop;
    logic pop;

    assign bit_end   = (cnt_q == BIT_LAST);
    assign last_stop = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);

    // Popping on the final stop cycle is what removes the idle gap between frames.
    assign pop            = !rst && fifo.fifo_val && ((state_q == IDLE) || last_stop);
    assign fifo.fifo_read = pop;

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Every state change happens on bit_end, so wrapping here also
        // restarts the bit timer for the new state.
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (pop) begin
                    state_d = START;
                    shift_d = fifo.fifo_data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        // tx is registered, so present the next bit one
                        // edge ahead: it is shift_q[1] before the shift.
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        if (pop) begin
                            state_d = START;
                            shift_d = fifo.fifo_data;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx (default and CLK_DIV=1/STOP_BITS=2)
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst;
    logic tx0, busy0, tx1, busy1;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_W(8)) if0 ();
    fifo_uart_tx_if #(.DATA_W(8)) if1 ();

    fifo_uart_tx #(.DATA_W(8), .CLK_DIV(4), .STOP_BITS(1)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (if0.slave),
        .tx   (tx0),
        .busy (busy0)
    );

    fifo_uart_tx #(.DATA_W(8), .CLK_DIV(1), .STOP_BITS(2)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .fifo (if1.slave),
        .tx   (tx1),
        .busy (busy1)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] wq[$];     // bench FIFO contents
    logic       exp_q[$];  // expected tx value, one entry per clock
    int         pop_log[$];
    int         cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v, input logic [7:0] d);
        if (b) begin
            if1.fifo_val  = v;
            if1.fifo_data = d;
        end else begin
            if0.fifo_val  = v;
            if0.fifo_data = d;
        end
    endtask

    task automatic frame_push(input logic [7:0] w, input int div, input int stops);
        for (int k = 0; k < div; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < div; k++) exp_q.push_back(w[i]);
        for (int k = 0; k < stops * div; k++) exp_q.push_back(1'b1);
    endtask

    // One clock of the scoreboard: drive FIFO, check outputs, advance.
    task automatic step(input bit b, input bit toggle);
        logic       v;
        logic [7:0] d;
        logic       er;
        logic       e;
        logic       rd, txs, bs;
        v = (wq.size() > 0);
        d = v ? wq[0] : (toggle ? 8'($urandom) : 8'h00);
        drive(b, v, d);
        #1;
        rd  = b ? if1.fifo_read : if0.fifo_read;
        txs = b ? tx1 : tx0;
        bs  = b ? busy1 : busy0;
        er  = v && (exp_q.size() <= 1);
        check("fifo_read", {31'b0, rd}, {31'b0, er});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx", {31'b0, txs}, {31'b0, e});
            check("busy", {31'b0, bs}, 32'd1);
        end else begin
            check("tx_idle", {31'b0, txs}, 32'd1);
            check("busy_idle", {31'b0, bs}, 32'd0);
        end
        if (er) begin
            frame_push(wq.pop_front(), b ? 1 : 4, b ? 2 : 1);
            pop_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_test();
        wq.delete();
        exp_q.delete();
        pop_log.delete();
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc = 0;
        drive(1'b0, 1'b1, 8'hA5);
        drive(1'b1, 1'b1, 8'h3C);

        // Reset held with fifo_val=1: no pops, line idle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_tx", {31'b0, tx0}, 32'd1);
            check("rst_busy", {31'b0, busy0}, 32'd0);
            check("rst_read", {31'b0, if0.fifo_read}, 32'd0);
            check("rst_read1", {31'b0, if1.fifo_read}, 32'd0);
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame 0xA5
        start_test();
        wq.push_back(8'hA5);
        for (int i = 0; i < 46; i++) step(1'b0, 1'b0);
        check("a5_pops", pop_log.size(), 1);
        check("a5_pop0", pop_log[0], 0);

        // Back-to-back 0x00 then 0xFF
        start_test();
        wq.push_back(8'h00);
        wq.push_back(8'hFF);
        for (int i = 0; i < 86; i++) step(1'b0, 1'b0);
        check("b2b_pops", pop_log.size(), 2);
        check("b2b_pop1", pop_log[1], 40);

        // CLK_DIV=1, STOP_BITS=2: 0x3C then 0x81 back to back
        start_test();
        wq.push_back(8'h3C);
        wq.push_back(8'h81);
        for (int i = 0; i < 26; i++) step(1'b1, 1'b0);
        check("d1_pops", pop_log.size(), 2);
        check("d1_pop1", pop_log[1], 11);

        // Late val and mid-frame data toggling
        start_test();
        wq.push_back(8'h5A);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        wq.push_back(8'hC3);
        for (int i = 0; i < 66; i++) step(1'b0, 1'b0);
        check("late_pops", pop_log.size(), 2);
        check("late_pop1", pop_log[1], 40);

        // Reset mid-frame at cycle 15 of a 0x55 frame
        start_test();
        wq.push_back(8'h55);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00);
        #1;
        check("pre_rst_busy", {31'b0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", {31'b0, tx0}, 32'd1);
        check("mid_rst_busy", {31'b0, busy0}, 32'd0);
        check("mid_rst_read", {31'b0, if0.fifo_read}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
